counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Sequencing controller for a WIDTH-bit synchronous count datapath. It latches a configuration (limit, direction, one-shot/auto-reload) through a valid/ready handshake. It then runs, pauses, resumes and stops the count under command inputs, and emits terminal-count and done pulses. It sits between a host/register interface and the counter/timer resources that downstream logic consumes.

Parameters:
WIDTH, 4, count and limit width in bits
PRESCALE_W, 4, prescaler divider width (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration can be accepted (high in IDLE and DONE only)
cfg_limit  input  WIDTH  terminal value (up mode) / reload value (down mode)
cfg_dir  input  1  0 = count up 0..limit, 1 = count down limit..0
cfg_mode  input  1  0 = one-shot, 1 = auto-reload
start  input  1  start (IDLE/DONE) or resume (PAUSED)
pause  input  1  freeze count while RUN
stop  input  1  abort to IDLE
count  output  WIDTH  current count value
busy  output  1  high in RUN or PAUSED
tc  output  1  one-cycle terminal-count pulse
done  output  1  one-cycle completion pulse (one-shot only)
state  output  2  IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, count=0, tc=0, done=0, busy=0; latched limit=all-ones, dir=0, mode=0. Reset mid-run aborts immediately; no tc/done pulse is emitted.
- Config accept = cfg_valid & cfg_ready. Latch limit/dir/mode. count <= (dir ? limit : 0). cfg_valid in RUN/PAUSED is ignored (cfg_ready=0) and not queued.
- Start value S = dir ? limit : 0. Terminal value T = dir ? 0 : limit.
- IDLE/DONE + start -> RUN next cycle; count <= S on entry. Config accept and start in the same cycle: the new config applies and S uses the new limit/dir.
- RUN, on each tick:
  - if count==T: tc<=1 for one cycle.
    - mode=1: count<=S, stay in RUN.
    - mode=0: count holds T, state<=DONE, done<=1 for one cycle.
  - else: count <= count±1 (modulo 2^WIDTH, never wraps in practice since limit ≤ 2^WIDTH-1).
- Example: up, limit=3, reload. Count sequence after start: 0,1,2,3,0,1. tc is visible in the cycle count shows 0 after 3.
- limit=0: terminal is reached on the first tick. Reload mode gives tc every tick with count stuck at 0.
- RUN + pause -> PAUSED; count frozen, no tick processed that cycle.
- PAUSED + start -> RUN; counting continues from the frozen value. pause in PAUSED is ignored. start in RUN is ignored.
- stop in RUN/PAUSED/DONE -> IDLE, count<=S, no tc/done pulse. stop in IDLE is a no-op.
- Command priority, same cycle: rst > stop > pause > start > tick.
- tc and done are registered; both deassert the following cycle unless they retrigger.
- busy and cfg_ready are decoded from state (registered state, no combinational input paths to outputs).

Optional Feature:
PRESCALER_EN:
- Defined:
  - Adds input cfg_div [PRESCALE_W-1:0], latched on config accept; reset value 0.
  - In RUN, tick asserts once every (div+1) clk cycles.
  - The prescaler counter clears on entry to RUN from IDLE/DONE and on stop/rst. It holds its value in PAUSED and resumes from it.
- Undefined: cfg_div port absent; tick=1 every clk cycle in RUN.

Test Plan:
- Reset with rst=1 mid-RUN (count=2) -> next cycle state=00, count=0, busy=0, tc=done=0; cfg_ready=1.
- Config limit=3, dir=0, mode=0; start -> count 0,1,2,3; tc and done pulse once with state=11 one cycle after count=3; count holds 3. A second start restarts from 0.
- Config limit=2, dir=1, mode=1; start -> count 2,1,0,2,1,0,2; tc pulses each time count returns to 2; done never asserts; busy=1 throughout.
- Up, limit=5: pause at count=2 for 4 cycles -> state=10, count stays 2. start -> count resumes at 3. cfg_valid during PAUSED is not accepted.
- stop, pause and start asserted together in RUN at count=4 -> IDLE, count=0, no tc. Config+start in the same cycle from DONE uses the new limit.
- PRESCALER_EN, div=2, up, limit=2, one-shot -> count advances every 3 clks: 0(x3),1(x3),2, then done. A pause mid-period preserves the prescaler phase.

Source files
------------

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Sequencing controller for a WIDTH-bit synchronous count datapath. A host
// offers a configuration (limit, direction, one-shot/auto-reload) through a
// valid/ready handshake. The block then runs, pauses, resumes and stops the
// count under command inputs, and emits registered terminal-count and done
// pulses.
//
// Optional feature macro: PRESCALER_EN
//   When defined, a cfg_div input is added. In RUN the count advances once
//   every (div+1) clocks. When undefined, the count advances every clock.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   configuration offered
//   cfg_ready  out  configuration can be accepted (IDLE and DONE only)
//   cfg_limit  in   terminal value (up) / reload value (down), WIDTH bits
//   cfg_dir    in   0 = count up 0..limit, 1 = count down limit..0
//   cfg_mode   in   0 = one-shot, 1 = auto-reload
//   cfg_div    in   prescaler divider, PRESCALE_W bits (PRESCALER_EN only)
//   start      in   start from IDLE/DONE, resume from PAUSED
//   pause      in   freeze the count while RUN
//   stop       in   abort to IDLE
//   count      out  current count value, WIDTH bits
//   busy       out  high in RUN or PAUSED
//   tc         out  one-cycle terminal-count pulse
//   done       out  one-cycle completion pulse (one-shot only)
//   state      out  IDLE=00, RUN=01, PAUSED=10, DONE=11
// -----------------------------------------------------------------------------
module counter_ctrl #(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [WIDTH-1:0]      cfg_limit,
   input  logic                  cfg_dir,
   input  logic                  cfg_mode,
`ifdef PRESCALER_EN
   input  logic [PRESCALE_W-1:0] cfg_div,
`endif
   input  logic                  start,
   input  logic                  pause,
   input  logic                  stop,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  tc,
   output logic                  done,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic [WIDTH-1:0]      limit_q, limit_d;
   logic                  dir_q, dir_d;
   logic                  mode_q, mode_d;
   logic                  tc_q, tc_d;
   logic                  done_q, done_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [PRESCALE_W-1:0] div_q;

   logic                  accept;
   logic                  tick;
   logic [WIDTH-1:0]      start_val;
   logic [WIDTH-1:0]      term_val;

`ifdef PRESCALER_EN
   logic [PRESCALE_W-1:0] div_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   always_comb begin
      div_d = div_q;
      if (accept) div_d = cfg_div;
   end
`else
   // Divider pinned to zero: the phase counter never leaves zero, so tick
   // fires every RUN cycle and the counter register reduces to a constant.
   assign div_q = '0;
`endif

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         limit_q <= '1;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
         pcnt_q  <= pcnt_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      accept  = cfg_valid & cfg_ready;
      limit_d = accept ? cfg_limit : limit_q;
      dir_d   = accept ? cfg_dir   : dir_q;
      mode_d  = accept ? cfg_mode  : mode_q;

      // Start value follows a configuration accepted in the same cycle.
      start_val = dir_d ? limit_d : '0;
      term_val  = dir_q ? '0 : limit_q;
      tick      = (pcnt_q == div_q);

      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = 1'b0;
      pcnt_d  = pcnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               count_d = start_val;
               pcnt_d  = '0;
            end else if (accept) begin
               count_d = start_val;
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
               count_d = start_val;
               pcnt_d  = '0;
            end else if (start) begin
               state_d = RUN;
               count_d = start_val;
               pcnt_d  = '0;
            end else if (accept) begin
               count_d = start_val;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               count_d = start_val;
               pcnt_d  = '0;
            end else if (pause) begin
               state_d = PAUSED;
            end else if (tick) begin
               pcnt_d = '0;
               if (count_q == term_val) begin
                  tc_d = 1'b1;
                  if (mode_q) begin
                     count_d = start_val;
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
               end
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         PAUSED: begin
            // Prescaler phase is held so a resume continues mid-period.
            if (stop) begin
               state_d = IDLE;
               count_d = start_val;
               pcnt_d  = '0;
            end else if (start) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------
   always_comb begin
      busy      = (state_q == RUN) || (state_q == PAUSED);
      cfg_ready = (state_q == IDLE) || (state_q == DONE);
      count     = count_q;
      tc        = tc_q;
      done      = done_q;
      state     = state_q;
   end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst, cfg_valid, cfg_dir, cfg_mode, start, pause, stop;
   logic [3:0] cfg_limit;
`ifdef PRESCALER_EN
   logic [3:0] cfg_div;
`endif
   logic       cfg_ready, busy, tc, done;
   logic [3:0] count;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_limit (cfg_limit),
      .cfg_dir   (cfg_dir),
      .cfg_mode  (cfg_mode),
`ifdef PRESCALER_EN
      .cfg_div   (cfg_div),
`endif
      .start     (start),
      .pause     (pause),
      .stop      (stop),
      .count     (count),
      .busy      (busy),
      .tc        (tc),
      .done      (done),
      .state     (state)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: state as a plain number 0..3, count stepped by the
   // rules, and ticks derived from elapsed active RUN cycles modulo (div+1).
   bit         m_ok = 1'b0;
   int         m_state, m_div, m_el;
   logic [3:0] m_count, m_lim;
   bit         m_dir, m_mode, m_tc, m_done;

   always @(posedge clk) begin : model
      bit         acc;
      logic [3:0] s, t;
      if (rst) begin
         m_ok = 1'b1; m_state = 0; m_count = 4'd0; m_tc = 1'b0; m_done = 1'b0;
         m_lim = 4'hF; m_dir = 1'b0; m_mode = 1'b0; m_div = 0; m_el = 0;
      end else if (m_ok) begin
         acc = cfg_valid && (m_state == 0 || m_state == 3);
         if (acc) begin
            m_lim = cfg_limit; m_dir = cfg_dir; m_mode = cfg_mode;
`ifdef PRESCALER_EN
            m_div = int'(cfg_div);
`endif
         end
         s = m_dir ? m_lim : 4'd0;
         t = m_dir ? 4'd0 : m_lim;
         m_tc = 1'b0; m_done = 1'b0;
         if ((m_state == 0 || m_state == 3) && !(stop && m_state == 3)) begin
            if (start) begin m_state = 1; m_count = s; m_el = 0; end
            else if (acc) m_count = s;
         end else if (stop) begin
            m_state = 0; m_count = s; m_el = 0;
         end else if (m_state == 1 && pause) begin
            m_state = 2;
         end else if (m_state == 2) begin
            if (start) m_state = 1;
         end else if (m_state == 1) begin
            m_el++;
            if (m_el % (m_div + 1) == 0) begin
               if (m_count == t) begin
                  m_tc = 1'b1;
                  if (m_mode) m_count = s;
                  else begin m_state = 3; m_done = 1'b1; end
               end else begin
                  m_count = m_dir ? m_count - 4'd1 : m_count + 4'd1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("state",     32'(state),     32'(m_state));
         chk("count",     32'(count),     32'(m_count));
         chk("tc",        32'(tc),        32'(m_tc));
         chk("done",      32'(done),      32'(m_done));
         chk("busy",      32'(busy),      32'(m_state == 1 || m_state == 2));
         chk("cfg_ready", 32'(cfg_ready), 32'(m_state == 0 || m_state == 3));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
   endtask

   task automatic cfg(input logic [3:0] lim, input bit dir, input bit mode, input logic [3:0] div);
      cfg_valid = 1'b1; cfg_limit = lim; cfg_dir = dir; cfg_mode = mode;
`ifdef PRESCALER_EN
      cfg_div = div;
`else
      if (div != 4'd0) $display("note: divider ignored without prescaler");
`endif
      cyc(1);
      cfg_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   initial begin
      quiet();
      cfg_limit = 4'd0; cfg_dir = 1'b0; cfg_mode = 1'b0;
`ifdef PRESCALER_EN
      cfg_div = 4'd0;
`endif
      rst = 1'b1; cyc(2); rst = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy",  32'(busy), 32'd0);

      // Up, limit 3, one-shot
      cfg(4'd3, 1'b0, 1'b0, 4'd0);
      go();
      chk("os_first", 32'(count), 32'd0);
      chk("os_run", 32'(state), 32'd1);
      cyc(3);
      chk("os_at3", 32'(count), 32'd3);
      chk("os_at3_tc", 32'(tc), 32'd0);
      cyc(1);
      chk("os_done_state", 32'(state), 32'd3);
      chk("os_done_tc", 32'(tc), 32'd1);
      chk("os_done_pulse", 32'(done), 32'd1);
      chk("os_hold", 32'(count), 32'd3);
      cyc(1);
      chk("os_done_clr", 32'(done), 32'd0);
      chk("os_tc_clr", 32'(tc), 32'd0);

      // Restart, then reset mid-run at count 2
      go();
      chk("restart", 32'(count), 32'd0);
      cyc(2);
      chk("pre_rst", 32'(count), 32'd2);
      rst = 1'b1; cyc(1); rst = 1'b0;
      chk("mrst_state", 32'(state), 32'd0);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_tc", 32'(tc), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_ready", 32'(cfg_ready), 32'd1);

      // Down, limit 2, reload
      cfg(4'd2, 1'b1, 1'b1, 4'd0);
      chk("dn_cfg_count", 32'(count), 32'd2);
      go();
      chk("dn_0", 32'(count), 32'd2);
      cyc(1); chk("dn_1", 32'(count), 32'd1);
      cyc(1); chk("dn_2", 32'(count), 32'd0);
      cyc(1);
      chk("dn_reload", 32'(count), 32'd2);
      chk("dn_tc", 32'(tc), 32'd1);
      chk("dn_nodone", 32'(done), 32'd0);
      chk("dn_busy", 32'(busy), 32'd1);
      cyc(1); chk("dn_after", 32'(count), 32'd1);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("dn_stop_state", 32'(state), 32'd0);
      chk("dn_stop_count", 32'(count), 32'd2);

      // Up, limit 5: pause, ignored config, resume
      cfg(4'd5, 1'b0, 1'b0, 4'd0);
      go();
      cyc(2);
      pause = 1'b1; cyc(1); pause = 1'b0;
      chk("pz_state", 32'(state), 32'd2);
      chk("pz_count", 32'(count), 32'd2);
      cfg_valid = 1'b1; cfg_limit = 4'd9; cfg_dir = 1'b1;
      cyc(3);
      cfg_valid = 1'b0;
      chk("pz_hold", 32'(count), 32'd2);
      chk("pz_ready", 32'(cfg_ready), 32'd0);
      go();
      chk("pz_resume_state", 32'(state), 32'd1);
      cyc(1); chk("pz_resume3", 32'(count), 32'd3);
      cyc(1); chk("pz_at4", 32'(count), 32'd4);
      stop = 1'b1; pause = 1'b1; start = 1'b1; cyc(1); quiet();
      chk("all_cmd_state", 32'(state), 32'd0);
      chk("all_cmd_count", 32'(count), 32'd0);
      chk("all_cmd_tc", 32'(tc), 32'd0);

      // Run to DONE, then config + start together
      go();
      cyc(6);
      chk("l5_done", 32'(state), 32'd3);
      cfg_valid = 1'b1; cfg_limit = 4'd1; cfg_dir = 1'b0; cfg_mode = 1'b0;
      start = 1'b1; cyc(1); quiet();
      chk("cs_count", 32'(count), 32'd0);
      cyc(1); chk("cs_at1", 32'(count), 32'd1);
      cyc(1);
      chk("cs_done", 32'(state), 32'd3);
      chk("cs_tc", 32'(tc), 32'd1);

      // limit 0, reload: tc every tick
      cfg(4'd0, 1'b0, 1'b1, 4'd0);
      go();
      chk("z_first_tc", 32'(tc), 32'd0);
      cyc(1); chk("z_tc1", 32'(tc), 32'd1); chk("z_cnt1", 32'(count), 32'd0);
      cyc(1); chk("z_tc2", 32'(tc), 32'd1); chk("z_state", 32'(state), 32'd1);
      stop = 1'b1; cyc(1); stop = 1'b0;

`ifdef PRESCALER_EN
      // div 2, up, limit 2, one-shot
      cfg(4'd2, 1'b0, 1'b0, 4'd2);
      go();
      chk("ps_c0a", 32'(count), 32'd0);
      cyc(2); chk("ps_c0c", 32'(count), 32'd0);
      cyc(1); chk("ps_c1a", 32'(count), 32'd1);
      cyc(2); chk("ps_c1c", 32'(count), 32'd1);
      cyc(1); chk("ps_c2a", 32'(count), 32'd2);
      cyc(2); chk("ps_nodone", 32'(done), 32'd0);
      cyc(1); chk("ps_done", 32'(done), 32'd1);
      // pause mid-period keeps phase
      go();
      cyc(1);
      pause = 1'b1; cyc(1); pause = 1'b0;
      cyc(2);
      go();
      chk("ps_res0", 32'(count), 32'd0);
      cyc(1); chk("ps_res1", 32'(count), 32'd0);
      cyc(1); chk("ps_res2", 32'(count), 32'd1);
      stop = 1'b1; cyc(1); stop = 1'b0;
`endif

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         stop      = ($urandom_range(0, 24) == 0);
         pause     = ($urandom_range(0, 9) == 0);
         start     = ($urandom_range(0, 5) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_limit = 4'($urandom_range(0, 15));
         cfg_dir   = 1'($urandom_range(0, 1));
         cfg_mode  = 1'($urandom_range(0, 1));
`ifdef PRESCALER_EN
         cfg_div   = 4'($urandom_range(0, 3));
`endif
         cyc(1);
      end
      quiet();
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
